load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage downstream of the instruction decoder. It consumes the decoded dm_en/dm_rw/size
//  controls, the ALU-computed address and the rs2 store data. It runs one aligned, byte-laned transaction on a
//  req/ready memory port and returns a sign/zero-extended load result with a done pulse. Misaligned accesses and
//  memory timeouts are flagged; the core is stalled via busy.
// PARAMETERS
//  TIMEOUT  16  max ACCESS cycles waiting for mem_ready before abort; 0 = wait forever
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   pipeline presents a memory instruction this cycle
//  dm_en        in   1   decoded: instruction accesses data memory
//  dm_rw        in   1   decoded: 0 = load, 1 = store
//  size         in   2   00 byte, 01 half, 10/11 word
//  ld_unsigned  in   1   instruction bit 14: 1 = zero-extend load (LBU/LHU)
//  addr         in   32  effective byte address from ALU
//  st_data      in   32  rs2 value for stores
//  busy         out  1   stall request to pipeline
//  done         out  1   1-cycle pulse, transaction finished
//  err          out  1   valid with done: misaligned or timeout
//  ld_data      out  32  load result, valid with done
//  mem_req      out  1   memory request, held until accepted
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word address {addr[31:2],2'b00}
//  mem_be       out  4   byte lane enables
//  mem_wdata    out  32  lane-replicated write data
//  mem_rdata    in   32  read data, valid when mem_ready=1
//  mem_ready    in   1   memory accepts/completes the request this cycle
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, DONE. Reset (async, rst_n=0): state IDLE, all outputs 0, ld_data 0, counter 0.
//  - Accept: in IDLE, when start=1 and dm_en=1, register addr, st_data, size, dm_rw and ld_unsigned.
//      - start with dm_en=0 is ignored.
//      - start in ACCESS or DONE is ignored; the pipeline must hold the instruction while busy=1.
//  - Misalignment check at accept: half with addr[0]=1, or word with addr[1:0]!=0.
//      - Next state DONE with err=1, no mem_req issued, ld_data=0.
//  - Otherwise the next state is ACCESS.
//  - ACCESS outputs:
//      - mem_req=1 and mem_we=registered rw.
//      - mem_addr, mem_be and mem_wdata come from registered values and are stable for the whole state.
//  - mem_be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
//  - mem_wdata: byte {4{st_data[7:0]}}; half {2{st_data[15:0]}}; word st_data.
//  - ACCESS exit on mem_ready=1 sampled at a rising edge: next state DONE, err=0.
//      - Load: select the lane from mem_rdata by addr[1:0] / addr[1].
//      - Load: sign-extend, or zero-extend if ld_unsigned, into ld_data. Store: ld_data=0, mem_rdata ignored.
//  - Timeout (TIMEOUT>0):
//      - The counter clears on entering ACCESS and increments each ACCESS cycle without mem_ready.
//      - If mem_ready=0 in the TIMEOUT-th ACCESS cycle: next state DONE with err=1, ld_data=0.
//      - mem_ready arriving in that same cycle wins (normal completion).
//  - DONE lasts exactly 1 cycle: done=1, mem_req=0, then IDLE.
//      - ld_data and err hold their values until the next accept.
//      - done=0 in all other states.
//  - busy = (state==ACCESS) | (state==IDLE & start & dm_en). It is combinational so the accept cycle stalls.
//      - busy=0 in DONE, so the pipeline advances with the result.
//  - Latency: accept edge -> ACCESS; N cycles until mem_ready; done asserted the cycle after mem_ready.
//      - With ready in the first ACCESS cycle: done is 2 cycles after start.
//  - Reset mid-ACCESS: mem_req drops immediately (async) and the transaction is discarded with no done pulse.
// TESTING
//  - Aligned load:
//      - Stimulus: LW addr=0x100, mem_ready=1 first ACCESS cycle, mem_rdata=0xDEADBEEF.
//      - Response: mem_addr=0x100, be=1111, done 2 cycles after start, ld_data=0xDEADBEEF, err=0.
//  - Byte/half loads:
//      - Stimulus: LB addr=0x103, rdata=0x80112233. Response: ld_data=0xFFFFFF80.
//      - LBU, same access: ld_data=0x00000080.
//      - LH addr=0x102: ld_data=0xFFFF8011.
//  - Store lanes:
//      - Stimulus: SB addr=0x201 st_data=0x000000A5.
//      - Response: be=0010, wdata=0xA5A5A5A5, we=1.
//      - SH addr=0x202 st_data=0x1234: be=1100, wdata=0x12341234.
//  - Misaligned:
//      - Stimulus: LW addr=0x102.
//      - Response: no mem_req ever, done next cycle, err=1, ld_data=0.
//  - Wait and timeout:
//      - mem_ready delayed 5 cycles: mem_req and mem_addr stable for 5 cycles, done the cycle after ready.
//      - mem_ready never (TIMEOUT=16): mem_req high exactly 16 cycles, then done=1, err=1.
//  - Robustness:
//      - start during ACCESS is ignored.
//      - rst_n low mid-ACCESS: mem_req=0 immediately, no done, IDLE after release.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - aligned byte-laned data-memory access stage with load extension and timeout
//
// Purpose: takes one decoded load/store from the pipeline, runs a single
// req/ready memory transaction and returns the extended load result with
// a one-cycle done pulse. Misaligned accesses and memory timeouts report err.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, dm_en, dm_rw, size,  decoded memory instruction from the pipeline
//   ld_unsigned, addr, st_data
//   busy                        stall request (combinational in the accept cycle)
//   done, err, ld_data          completion pulse, error flag and load result
//   mem_req, mem_we, mem_addr,  memory request side, stable for the whole access
//   mem_be, mem_wdata
//   mem_rdata, mem_ready        memory response side
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dm_en,
    input  logic        dm_rw,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ld_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit when timeouts are disabled.
    localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          rw_q, rw_d;
    logic          uns_q, uns_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   ld_q, ld_d;

    logic          accept;
    logic          misaligned;
    logic          in_access;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_ext;

    assign accept     = (state_q == IDLE) && start && dm_en;
    assign misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
    assign in_access  = (state_q == ACCESS);

    assign busy      = in_access || accept;
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign ld_data   = ld_q;
    assign mem_req   = in_access;
    assign mem_we    = in_access && rw_q;
    assign mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;

    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        if (in_access) begin
            case (size_q)
                2'b00: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
    end

    // Lane select and extension of the returned word.
    always_comb begin
        rd_byte = 8'd0;
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   ld_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rw_d    = rw_q;
        uns_d   = uns_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ld_d    = ld_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = addr;
                    wdata_d = st_data;
                    size_d  = size;
                    rw_d    = dm_rw;
                    uns_d   = ld_unsigned;
                    cnt_d   = '0;
                    ld_d    = 32'd0;
                    if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    ld_d    = rw_q ? 32'd0 : ld_ext;
                end else if ((TIMEOUT > 0) && (cnt_q == LAST)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    ld_d    = 32'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            rw_q    <= 1'b0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ld_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            uns_q   <= uns_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dm_en = 1'b0;
    logic        dm_rw = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        ld_unsigned = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb[$];   // {err, ld_data}

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dm_en(dm_en), .dm_rw(dm_rw),
        .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .st_data(st_data),
        .busy(busy), .done(done), .err(err), .ld_data(ld_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued response.
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [32:0] e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got err=%0b ld=0x%08h expected no done", err, ld_data);
            end else begin
                e = sb.pop_front();
                if ({err, ld_data} !== e) begin
                    n_fail++;
                    $display("FAIL response: got err=%0b ld=0x%08h expected err=%0b ld=0x%08h",
                             err, ld_data, e[32], e[31:0]);
                end
            end
        end
    end

    // One transaction; dly = number of ACCESS cycles before mem_ready, dly<0 = misaligned (no access).
    task automatic txn(input string nm, input logic rw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] st, input logic [31:0] rd,
                       input int dly, input logic xerr, input logic [31:0] xld,
                       input logic [3:0] xbe, input logic [31:0] xwd);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        @(negedge clk);
        start = 1'b1; dm_en = 1'b1; dm_rw = rw; size = sz; ld_unsigned = uns;
        addr = a; st_data = st; mem_ready = 1'b0;
        sb.push_back({xerr, xld});
        #1 chk({nm, "_busy_accept"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0; dm_en = 1'b0;
        if (dly < 0) begin
            chk({nm, "_no_req"}, {31'd0, mem_req}, 32'd0);
            chk({nm, "_done_next"}, {31'd0, done}, 32'd1);
        end else begin
            for (int i = 0; i <= dly; i++) begin
                chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
                chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, rw});
                chk({nm, "_addr"}, mem_addr, wa);
                chk({nm, "_be"}, {28'd0, mem_be}, {28'd0, xbe});
                chk({nm, "_wdata"}, mem_wdata, xwd);
                chk({nm, "_done_low"}, {31'd0, done}, 32'd0);
                if (i == dly) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd;
                end
                @(negedge clk);
            end
            mem_ready = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            chk({nm, "_done"}, {31'd0, done}, 32'd1);
            chk({nm, "_req_off"}, {31'd0, mem_req}, 32'd0);
            chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        chk({nm, "_done_1cyc"}, {31'd0, done}, 32'd0);
        chk({nm, "_hold_err"}, {31'd0, err}, {31'd0, xerr});
        chk({nm, "_hold_ld"}, ld_data, xld);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ld", ld_data, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;

        // name          rw    sz     uns   addr          st_data        rdata          dly xerr  exp ld_data     be       wdata
        txn("lw",        1'b0, 2'b10, 1'b0, 32'h100, 32'h0,         32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0);
        txn("lb",        1'b0, 2'b00, 1'b0, 32'h103, 32'h0,         32'h80112233, 0, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h0);
        txn("lbu",       1'b0, 2'b00, 1'b1, 32'h103, 32'h0,         32'h80112233, 0, 1'b0, 32'h00000080, 4'b1000, 32'h0);
        txn("lh",        1'b0, 2'b01, 1'b0, 32'h102, 32'h0,         32'h80112233, 0, 1'b0, 32'hFFFF8011, 4'b1100, 32'h0);
        txn("lh_lo",     1'b0, 2'b01, 1'b0, 32'h100, 32'h0,         32'h1234ABCD, 1, 1'b0, 32'hFFFFABCD, 4'b0011, 32'h0);
        txn("lhu_lo",    1'b0, 2'b01, 1'b1, 32'h100, 32'h0,         32'h1234ABCD, 0, 1'b0, 32'h0000ABCD, 4'b0011, 32'h0);
        txn("sb",        1'b1, 2'b00, 1'b0, 32'h201, 32'h000000A5,  32'hFFFFFFFF, 0, 1'b0, 32'h00000000, 4'b0010, 32'hA5A5A5A5);
        txn("sh",        1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234,  32'hFFFFFFFF, 0, 1'b0, 32'h00000000, 4'b1100, 32'h12341234);
        txn("sw",        1'b1, 2'b11, 1'b0, 32'h300, 32'hCAFEF00D,  32'hFFFFFFFF, 2, 1'b0, 32'h00000000, 4'b1111, 32'hCAFEF00D);
        txn("mis_lw",    1'b0, 2'b10, 1'b0, 32'h102, 32'h0,         32'h0,        -1, 1'b1, 32'h00000000, 4'b0000, 32'h0);
        txn("mis_lh",    1'b0, 2'b01, 1'b0, 32'h101, 32'h0,         32'h0,        -1, 1'b1, 32'h00000000, 4'b0000, 32'h0);
        txn("lw_wait5",  1'b0, 2'b10, 1'b0, 32'h104, 32'h0,         32'h01020304, 5, 1'b0, 32'h01020304, 4'b1111, 32'h0);

        // start with dm_en=0 is ignored
        @(negedge clk);
        start = 1'b1; dm_en = 1'b0; addr = 32'h400; size = 2'b10;
        #1 chk("noen_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("noen_req", {31'd0, mem_req}, 32'd0);
        chk("noen_done", {31'd0, done}, 32'd0);

        // timeout: mem_ready never arrives
        @(negedge clk);
        start = 1'b1; dm_en = 1'b1; dm_rw = 1'b0; size = 2'b10; addr = 32'h500; mem_ready = 1'b0;
        sb.push_back({1'b1, 32'h0});
        @(negedge clk);
        start = 1'b0; dm_en = 1'b0;
        reqs = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            reqs++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", reqs, 32'd16);
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_err", {31'd0, err}, 32'd1);
        @(negedge clk);

        // start during ACCESS is ignored
        @(negedge clk);
        start = 1'b1; dm_en = 1'b1; dm_rw = 1'b0; size = 2'b10; addr = 32'h600; ld_unsigned = 1'b0;
        sb.push_back({1'b0, 32'h0000BEEF});
        @(negedge clk);
        addr = 32'h704; size = 2'b00; dm_rw = 1'b1;   // new instruction presented while busy
        #1 chk("ign_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("ign_addr", mem_addr, 32'h600);
        chk("ign_be", {28'd0, mem_be}, 32'hF);
        chk("ign_we", {31'd0, mem_we}, 32'd0);
        start = 1'b0; dm_en = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h0000BEEF;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("ign_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("ign_idle", {31'd0, mem_req}, 32'd0);

        // reset mid-ACCESS drops the request immediately with no done
        @(negedge clk);
        start = 1'b1; dm_en = 1'b1; dm_rw = 1'b0; size = 2'b10; addr = 32'h800;
        @(negedge clk);
        start = 1'b0; dm_en = 1'b0;
        chk("rstm_req_before", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rstm_req_async", {31'd0, mem_req}, 32'd0);
        chk("rstm_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstm_no_done", {31'd0, done}, 32'd0);
            chk("rstm_idle", {31'd0, mem_req}, 32'd0);
        end
        mem_ready = 1'b0;

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
